// File: rtl/dmem_access_ctrl_if.sv
// ----------------------------------------------------------------------------
// dmem_access_ctrl_if
// Request/acknowledge bus between the data-memory access controller and a
// variable-latency data memory.
//
// Signals (named from the controller's point of view):
//   mem_req_o    controller -> memory  request, held until acknowledged
//   mem_we_o     controller -> memory  1 = write, 0 = read
//   mem_addr_o   controller -> memory  byte address   [ADDR_WIDTH-1:0]
//   mem_wdata_o  controller -> memory  store data     [DATA_WIDTH-1:0]
//   mem_ack_i    memory -> controller  completion strobe
//   mem_rdata_i  memory -> controller  load data, valid with mem_ack_i on reads
//
// Modports: master = controller side, slave = memory side.
// ----------------------------------------------------------------------------
interface dmem_access_ctrl_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                  mem_req_o;
    logic                  mem_we_o;
    logic [ADDR_WIDTH-1:0] mem_addr_o;
    logic [DATA_WIDTH-1:0] mem_wdata_o;
    logic                  mem_ack_i;
    logic [DATA_WIDTH-1:0] mem_rdata_i;

    modport master (
        output mem_req_o,
        output mem_we_o,
        output mem_addr_o,
        output mem_wdata_o,
        input  mem_ack_i,
        input  mem_rdata_i
    );

    modport slave (
        input  mem_req_o,
        input  mem_we_o,
        input  mem_addr_o,
        input  mem_wdata_o,
        output mem_ack_i,
        output mem_rdata_i
    );
endinterface

// File: rtl/dmem_access_ctrl.sv
// ----------------------------------------------------------------------------
// dmem_access_ctrl
// Turns the core's single-cycle MemRead/MemWrite intent into a req/ack
// transaction on a variable-latency data memory. The core is stalled from the
// cycle the request is seen until the memory acknowledges; load data is
// returned registered together with a one-cycle rvalid_o pulse.
//
// Optional feature (macro DMEM_ACCESS_CTRL_TIMEOUT_EN):
//   When defined, an access that waits TIMEOUT_CYCLES cycles without an ack
//   is abandoned: err_o pulses, rdata_o loads 0 and rvalid_o still pulses for
//   a read. When undefined, ACCESS waits indefinitely and err_o is tied to 0.
//
// Ports:
//   clk          clock, rising edge
//   rst_n        synchronous active-low reset
//   mem_read_i   load request from the decoder
//   mem_write_i  store request from the decoder (wins over mem_read_i)
//   addr_i       access address (ALU result)
//   wdata_i      store data (rs2)
//   stall_o      combinational stall to the core
//   rdata_o      registered load data, held until the next completed load
//   rvalid_o     one-cycle pulse when a load completes
//   err_o        one-cycle pulse when an access times out
//   mem          memory bus (master modport)
// ----------------------------------------------------------------------------
module dmem_access_ctrl #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  mem_read_i,
    input  logic                  mem_write_i,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    output logic                  stall_o,
    output logic [DATA_WIDTH-1:0] rdata_o,
    output logic                  rvalid_o,
    output logic                  err_o,
    dmem_access_ctrl_if.master    mem
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ACCESS = 2'd1;
    localparam logic [1:0] DONE   = 2'd2;

    logic [1:0] state;
    logic       req_seen;

    assign req_seen = mem_read_i | mem_write_i;

    // The stall must cover the request cycle itself, so it cannot be registered.
    assign stall_o = ((state == IDLE) && req_seen) || (state == ACCESS);

`ifdef DMEM_ACCESS_CTRL_TIMEOUT_EN
    // Counter value seen in the last permitted ACCESS cycle (counter is 0 in
    // the first one), so TIMEOUT_CYCLES ACCESS cycles elapse before giving up.
    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

    logic [7:0] wait_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state           <= IDLE;
            rdata_o         <= '0;
            rvalid_o        <= 1'b0;
            err_o           <= 1'b0;
            mem.mem_req_o   <= 1'b0;
            mem.mem_we_o    <= 1'b0;
            mem.mem_addr_o  <= '0;
            mem.mem_wdata_o <= '0;
            wait_cnt        <= 8'd0;
        end else begin
            rvalid_o <= 1'b0;
            err_o    <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_seen) begin
                        state           <= ACCESS;
                        mem.mem_req_o   <= 1'b1;
                        mem.mem_we_o    <= mem_write_i;
                        mem.mem_addr_o  <= addr_i;
                        mem.mem_wdata_o <= wdata_i;
                        wait_cnt        <= 8'd0;
                    end
                end
                ACCESS: begin
                    // An ack in the timeout cycle still counts as a normal completion.
                    if (mem.mem_ack_i) begin
                        state         <= DONE;
                        mem.mem_req_o <= 1'b0;
                        if (!mem.mem_we_o) begin
                            rdata_o  <= mem.mem_rdata_i;
                            rvalid_o <= 1'b1;
                        end
                    end else if (wait_cnt == TIMEOUT_LAST) begin
                        state         <= DONE;
                        mem.mem_req_o <= 1'b0;
                        err_o         <= 1'b1;
                        rdata_o       <= '0;
                        rvalid_o      <= ~mem.mem_we_o;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                DONE: begin
                    // Request inputs still belong to the retiring instruction.
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
`else
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state           <= IDLE;
            rdata_o         <= '0;
            rvalid_o        <= 1'b0;
            mem.mem_req_o   <= 1'b0;
            mem.mem_we_o    <= 1'b0;
            mem.mem_addr_o  <= '0;
            mem.mem_wdata_o <= '0;
        end else begin
            rvalid_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_seen) begin
                        state           <= ACCESS;
                        mem.mem_req_o   <= 1'b1;
                        mem.mem_we_o    <= mem_write_i;
                        mem.mem_addr_o  <= addr_i;
                        mem.mem_wdata_o <= wdata_i;
                    end
                end
                ACCESS: begin
                    if (mem.mem_ack_i) begin
                        state         <= DONE;
                        mem.mem_req_o <= 1'b0;
                        if (!mem.mem_we_o) begin
                            rdata_o  <= mem.mem_rdata_i;
                            rvalid_o <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    // Request inputs still belong to the retiring instruction.
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// ----------------------------------------------------------------------------
// tb_dmem_access_ctrl
// Directed testbench for dmem_access_ctrl. Inputs are driven 1 ns after the
// rising edge and outputs are sampled 2 ns after it. Timeout cases are built
// only when DMEM_ACCESS_CTRL_TIMEOUT_EN is defined (TIMEOUT_CYCLES = 4).
// ----------------------------------------------------------------------------
module tb_dmem_access_ctrl;

    logic        clk;
    logic        rst_n;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        stall;
    logic [31:0] rdata;
    logic        rvalid;
    logic        err;

    int checks;
    int errors;

    dmem_access_ctrl_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) mem_bus ();

    dmem_access_ctrl #(
        .ADDR_WIDTH    (32),
        .DATA_WIDTH    (32),
        .TIMEOUT_CYCLES(4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .mem_read_i (mem_read),
        .mem_write_i(mem_write),
        .addr_i     (addr),
        .wdata_i    (wdata),
        .stall_o    (stall),
        .rdata_o    (rdata),
        .rvalid_o   (rvalid),
        .err_o      (err),
        .mem        (mem_bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed,
                         input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, observed, expected);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Let combinational outputs settle after input changes.
    task automatic settle();
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, ".stall"},  32'(stall),               32'd0);
        check({tag, ".rvalid"}, 32'(rvalid),              32'd0);
        check({tag, ".err"},    32'(err),                 32'd0);
        check({tag, ".req"},    32'(mem_bus.mem_req_o),   32'd0);
        check({tag, ".we"},     32'(mem_bus.mem_we_o),    32'd0);
        check({tag, ".addr"},   mem_bus.mem_addr_o,       32'd0);
        check({tag, ".wdata"},  mem_bus.mem_wdata_o,      32'd0);
        check({tag, ".rdata"},  rdata,                    32'd0);
    endtask

    initial begin
        checks              = 0;
        errors              = 0;
        rst_n               = 1'b0;
        mem_read            = 1'b0;
        mem_write           = 1'b0;
        addr                = 32'd0;
        wdata               = 32'd0;
        mem_bus.mem_ack_i   = 1'b0;
        mem_bus.mem_rdata_i = 32'd0;

        cyc();
        cyc();
        settle();
        check_reset_outputs("reset");
        rst_n = 1'b1;

        // Zero-wait load
        cyc();
        mem_read = 1'b1; addr = 32'h0000_0100;
        settle();
        check("ld0.c0.stall", 32'(stall), 32'd1);
        check("ld0.c0.req",   32'(mem_bus.mem_req_o), 32'd0);
        cyc();
        mem_bus.mem_ack_i = 1'b1; mem_bus.mem_rdata_i = 32'hCAFE_F00D;
        settle();
        check("ld0.c1.stall", 32'(stall), 32'd1);
        check("ld0.c1.req",   32'(mem_bus.mem_req_o), 32'd1);
        check("ld0.c1.we",    32'(mem_bus.mem_we_o), 32'd0);
        check("ld0.c1.addr",  mem_bus.mem_addr_o, 32'h0000_0100);
        cyc();
        mem_bus.mem_ack_i = 1'b0; mem_bus.mem_rdata_i = 32'd0; mem_read = 1'b0;
        settle();
        check("ld0.c2.stall",  32'(stall), 32'd0);
        check("ld0.c2.rvalid", 32'(rvalid), 32'd1);
        check("ld0.c2.rdata",  rdata, 32'hCAFE_F00D);
        check("ld0.c2.req",    32'(mem_bus.mem_req_o), 32'd0);
        cyc();
        settle();
        check("ld0.c3.rvalid", 32'(rvalid), 32'd0);
        check("ld0.c3.rdata",  rdata, 32'hCAFE_F00D);

        // 3-wait store
        mem_write = 1'b1; addr = 32'h0000_0204; wdata = 32'h1234_5678;
        settle();
        check("st3.c0.stall", 32'(stall), 32'd1);
        for (int i = 0; i < 4; i++) begin
            cyc();
            mem_bus.mem_ack_i = (i == 3);
            settle();
            check($sformatf("st3.a%0d.req", i),   32'(mem_bus.mem_req_o), 32'd1);
            check($sformatf("st3.a%0d.we", i),    32'(mem_bus.mem_we_o), 32'd1);
            check($sformatf("st3.a%0d.addr", i),  mem_bus.mem_addr_o, 32'h0000_0204);
            check($sformatf("st3.a%0d.wdata", i), mem_bus.mem_wdata_o, 32'h1234_5678);
            check($sformatf("st3.a%0d.stall", i), 32'(stall), 32'd1);
        end
        cyc();
        mem_bus.mem_ack_i = 1'b0; mem_write = 1'b0;
        settle();
        check("st3.done.stall",  32'(stall), 32'd0);
        check("st3.done.rvalid", 32'(rvalid), 32'd0);
        check("st3.done.req",    32'(mem_bus.mem_req_o), 32'd0);
        check("st3.done.rdata",  rdata, 32'hCAFE_F00D);
        cyc();

        // Back-to-back load then store
        mem_read = 1'b1; addr = 32'h0000_0300;
        cyc();
        mem_bus.mem_ack_i = 1'b1; mem_bus.mem_rdata_i = 32'h1111_2222;
        settle();
        check("b2b.ld.addr", mem_bus.mem_addr_o, 32'h0000_0300);
        cyc();
        mem_bus.mem_ack_i = 1'b0; mem_read = 1'b0;
        mem_write = 1'b1; addr = 32'h0000_0304; wdata = 32'hA5A5_A5A5;
        settle();
        check("b2b.done1.stall",  32'(stall), 32'd0);
        check("b2b.done1.rvalid", 32'(rvalid), 32'd1);
        check("b2b.done1.rdata",  rdata, 32'h1111_2222);
        cyc();
        settle();
        check("b2b.idle.stall", 32'(stall), 32'd1);
        check("b2b.idle.req",   32'(mem_bus.mem_req_o), 32'd0);
        cyc();
        mem_bus.mem_ack_i = 1'b1;
        settle();
        check("b2b.st.req",   32'(mem_bus.mem_req_o), 32'd1);
        check("b2b.st.we",    32'(mem_bus.mem_we_o), 32'd1);
        check("b2b.st.addr",  mem_bus.mem_addr_o, 32'h0000_0304);
        check("b2b.st.wdata", mem_bus.mem_wdata_o, 32'hA5A5_A5A5);
        cyc();
        mem_bus.mem_ack_i = 1'b0; mem_write = 1'b0;
        settle();
        check("b2b.done2.rvalid", 32'(rvalid), 32'd0);
        check("b2b.done2.rdata",  rdata, 32'h1111_2222);
        cyc();

        // Read and write both high: write wins
        mem_read = 1'b1; mem_write = 1'b1; addr = 32'h0000_0040; wdata = 32'hDEAD_BEEF;
        cyc();
        mem_bus.mem_ack_i = 1'b1; mem_bus.mem_rdata_i = 32'h9999_9999;
        settle();
        check("both.we",    32'(mem_bus.mem_we_o), 32'd1);
        check("both.wdata", mem_bus.mem_wdata_o, 32'hDEAD_BEEF);
        cyc();
        mem_bus.mem_ack_i = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
        settle();
        check("both.rvalid", 32'(rvalid), 32'd0);
        check("both.rdata",  rdata, 32'h1111_2222);
        cyc();

        // Reset during the second ACCESS cycle
        mem_read = 1'b1; addr = 32'h0000_0500; wdata = 32'h0000_0077;
        cyc();
        cyc();
        rst_n = 1'b0; mem_read = 1'b0;
        settle();
        check("rstmid.req_before", 32'(mem_bus.mem_req_o), 32'd1);
        cyc();
        settle();
        check_reset_outputs("rstmid");
        rst_n = 1'b1;
        cyc();
        mem_read = 1'b1; addr = 32'h0000_0600;
        cyc();
        mem_bus.mem_ack_i = 1'b1; mem_bus.mem_rdata_i = 32'h0BAD_F00D;
        settle();
        check("rstmid.ld.addr", mem_bus.mem_addr_o, 32'h0000_0600);
        cyc();
        mem_bus.mem_ack_i = 1'b0; mem_read = 1'b0;
        settle();
        check("rstmid.ld.rvalid", 32'(rvalid), 32'd1);
        check("rstmid.ld.rdata",  rdata, 32'h0BAD_F00D);
        cyc();

`ifdef DMEM_ACCESS_CTRL_TIMEOUT_EN
        // Timeout with no ack (TIMEOUT_CYCLES = 4)
        mem_read = 1'b1; addr = 32'h0000_0700;
        for (int i = 0; i < 4; i++) begin
            cyc();
            settle();
            check($sformatf("to.a%0d.req", i), 32'(mem_bus.mem_req_o), 32'd1);
            check($sformatf("to.a%0d.err", i), 32'(err), 32'd0);
        end
        cyc();
        mem_read = 1'b0;
        mem_bus.mem_ack_i = 1'b1; mem_bus.mem_rdata_i = 32'h7777_7777;
        settle();
        check("to.done.err",    32'(err), 32'd1);
        check("to.done.rvalid", 32'(rvalid), 32'd1);
        check("to.done.rdata",  rdata, 32'd0);
        check("to.done.stall",  32'(stall), 32'd0);
        check("to.done.req",    32'(mem_bus.mem_req_o), 32'd0);
        cyc();
        mem_bus.mem_ack_i = 1'b0;
        settle();
        check("to.idle.err",    32'(err), 32'd0);
        check("to.idle.rvalid", 32'(rvalid), 32'd0);
        check("to.idle.rdata",  rdata, 32'd0);
        check("to.idle.req",    32'(mem_bus.mem_req_o), 32'd0);

        // Ack in the 4th ACCESS cycle completes normally
        mem_read = 1'b1; addr = 32'h0000_0800;
        for (int i = 0; i < 4; i++) begin
            cyc();
            mem_bus.mem_ack_i = (i == 3); mem_bus.mem_rdata_i = 32'h5555_AAAA;
        end
        cyc();
        mem_bus.mem_ack_i = 1'b0; mem_read = 1'b0;
        settle();
        check("to4.done.err",    32'(err), 32'd0);
        check("to4.done.rvalid", 32'(rvalid), 32'd1);
        check("to4.done.rdata",  rdata, 32'h5555_AAAA);
        cyc();
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dmem_access_ctrl.md
# dmem_access_ctrl

Sequencer between the RISC-V core's data-memory control signals (MemRead/MemWrite from the main decoder, ALU address, rs2 store data) and a variable-latency data memory with a req/ack handshake. Converts single-cycle load/store intent into a multi-cycle memory transaction. Stalls the core until the transaction completes, then returns registered load data.

## Interface
- ADDR_WIDTH, 32, byte address width
- DATA_WIDTH, 32, data word width
- TIMEOUT_CYCLES, 255, maximum cycles waiting for mem_ack_i; only used with the timeout feature; legal range 1..255
- clk  in  1  clock; all logic on rising edge
- rst_n  in  1  synchronous, active-low reset
- mem_read_i  in  1  load request (decoder MemRead)
- mem_write_i  in  1  store request (decoder MemWrite)
- addr_i  in  ADDR_WIDTH  access address (ALU result)
- wdata_i  in  DATA_WIDTH  store data
- stall_o  out  1  freezes core PC and pipeline state
- rdata_o  out  DATA_WIDTH  registered load data
- rvalid_o  out  1  one-cycle pulse when a load completes
- err_o  out  1  one-cycle pulse when an access times out
- mem_req_o  out  1  memory request, held until ack
- mem_we_o  out  1  1 = write, 0 = read
- mem_addr_o  out  ADDR_WIDTH  latched address
- mem_wdata_o  out  DATA_WIDTH  latched store data
- mem_ack_i  in  1  memory completion; can arrive in the same cycle as mem_req_o
- mem_rdata_i  in  DATA_WIDTH  read data; valid when mem_ack_i = 1 and mem_we_o = 0

## Operation
- FSM states: IDLE, ACCESS, DONE.
- **IDLE**
  - If mem_read_i or mem_write_i is high: latch addr_i, wdata_i and the access type (mem_write_i wins if both are high), then go to ACCESS.
  - Otherwise stay in IDLE.
  - mem_ack_i is ignored in IDLE.
- **ACCESS**
  - mem_req_o = 1; mem_we_o, mem_addr_o and mem_wdata_o are held stable from the latched values.
  - On mem_ack_i: go to DONE. For a read, capture mem_rdata_i into rdata_o.
  - Wait cycles are counted in an 8-bit counter that clears on entry to ACCESS.
- **DONE**
  - stall_o = 0. rvalid_o = 1 if the access was a read.
  - Go to IDLE unconditionally. mem_read_i/mem_write_i are ignored here, because they still belong to the retiring instruction.
- stall_o (combinational) = (IDLE & (mem_read_i | mem_write_i)) | ACCESS.
- rdata_o holds its value until the next completed load; it is not changed by stores.
- Reset values: state = IDLE, stall_o = 0, rdata_o = 0, rvalid_o = 0, err_o = 0, mem_req_o = 0, mem_we_o = 0, mem_addr_o = 0, mem_wdata_o = 0, wait counter = 0.
- Reset asserted mid-ACCESS: the transaction is abandoned and mem_req_o drops at the next edge. The memory side must tolerate the dropped request.

## Timing
- Cycle 0 (IDLE, request seen): stall_o = 1.
- Cycle 1 (ACCESS): mem_req_o = 1. With a zero-wait memory, mem_ack_i = 1 in this cycle.
- Cycle 2 (DONE): stall_o = 0, rvalid_o/rdata_o valid.
- Minimum of 2 stall cycles per access; each memory wait cycle adds one stall cycle.
- Back-to-back memory instructions: the next request is sampled in the IDLE cycle after DONE, giving one non-stalled cycle between accesses.
- All outputs except stall_o are registered.

## Configuration
- Macro: DMEM_ACCESS_CTRL_TIMEOUT_EN.
- **Defined:**
  - If the wait counter reaches TIMEOUT_CYCLES in ACCESS without mem_ack_i, go to DONE with err_o = 1.
  - mem_req_o deasserts and rdata_o loads 0.
  - rvalid_o still pulses for a read, so the core is never left hanging.
  - An ack arriving in the same cycle as the timeout takes priority: normal completion, no error.
  - A late ack after the timeout arrives in IDLE/DONE and is ignored.
- **Not defined:** ACCESS waits indefinitely for mem_ack_i, err_o is tied to 0, and the counter is not synthesized.

## Test plan
- Zero-wait load: mem_read_i = 1, addr_i = 0x100, ack in the first ACCESS cycle with mem_rdata_i = 0xCAFEF00D -> stall_o high for 2 cycles, rvalid_o pulses, rdata_o = 0xCAFEF00D.
- 3-wait store: mem_write_i = 1, addr_i = 0x204, wdata_i = 0x12345678, ack after 3 cycles -> mem_req_o high for 4 cycles with constant mem_we_o = 1 and data; stall_o high for 5 cycles; rvalid_o stays 0; rdata_o unchanged.
- Back-to-back load then store -> second mem_req_o rises exactly 2 cycles after the first DONE; both transactions complete with the correct addresses.
- Both mem_read_i and mem_write_i high -> mem_we_o = 1 and a write is performed.
- Reset mid-access: rst_n = 0 during the second ACCESS cycle -> all outputs at reset values after the next edge; a fresh load then completes normally.
- With DMEM_ACCESS_CTRL_TIMEOUT_EN and TIMEOUT_CYCLES = 4, no ack -> DONE after 4 ACCESS cycles, err_o = 1 and rvalid_o = 1 for one cycle, rdata_o = 0, stall_o released. Also check that an ack exactly at the 4th cycle completes normally with no error.
